// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: parametrised single-clock show-ahead FIFO with occupancy
// count, programmable almost-full/almost-empty levels and overflow/underflow
// reporting. Define FIFO_ERR_STICKY_EN to make the error flags sticky
// (cleared by err_clr); otherwise they are one-cycle pulses.
module fifo_sync_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned        DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   w_ptr;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ovf_ev;
  logic                  unf_ev;

  // Wrap bits are kept for pointer compatibility; occupancy comes from count.
  logic unused_ptr_msb;
  assign unused_ptr_msb = w_ptr[ADDR_WIDTH] ^ r_ptr[ADDR_WIDTH];

  // A write into a full FIFO is accepted when a pop frees the head slot.
  assign wr_en  = wr & (~full | rd);
  assign rd_en  = rd & ~empty;
  assign ovf_ev = wr & full & ~rd;
  assign unf_ev = rd & empty;

  assign r_data       = mem[r_ptr[ADDR_WIDTH-1:0]];
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign almost_full  = (count >= AF_CNT);

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[w_ptr[ADDR_WIDTH-1:0]] <= w_data;
  end

  // Next occupancy from the accepted operations.
  always_comb begin
    count_nxt = count;
    unique case ({wr_en, rd_en})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) w_ptr <= w_ptr + 1'b1;
      if (rd_en) r_ptr <= r_ptr + 1'b1;
      count <= count_nxt;
    end
  end

`ifdef FIFO_ERR_STICKY_EN
  // Sticky error flags; a new event in the clearing cycle takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_ev)       overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (unf_ev)       underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  // One-cycle error pulses following each dropping edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_ev;
      underflow <= unf_ev;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench for fifo_sync_flags (DEPTH=8, AF_LEVEL=7, AE_LEVEL=1):
// a constant vector table, hand-written corner sequences, and randomized
// traffic against a queue-based reference model.
module tb_fifo_sync_flags;

`ifdef FIFO_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr, rd, err_clr;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full;
  logic [3:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  fifo_sync_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(7), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] wd;
    logic       rv;
    logic [7:0] exp_rd;
    int         exp_cnt;
    logic       exp_ovf, exp_unf;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] m_q[$];
  logic       m_ovf, m_unf;

  function automatic vec_t mk(logic w, logic r, logic c, logic [7:0] d,
                              logic rv, logic [7:0] er, int ec, logic eo, logic eu);
    vec_t v;
    v.wr = w; v.rd = r; v.clr = c; v.wd = d; v.rv = rv; v.exp_rd = er;
    v.exp_cnt = ec; v.exp_ovf = eo; v.exp_unf = eu;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare count, the four level flags (from level rules) and error flags.
  task automatic check_state(input string tag, input int ecnt, input logic eo, input logic eu);
    chk({tag, ".count"}, int'(count), ecnt);
    chk({tag, ".empty"}, int'(empty), int'(ecnt == 0));
    chk({tag, ".full"}, int'(full), int'(ecnt == DEPTH));
    chk({tag, ".almost_empty"}, int'(almost_empty), int'(ecnt <= 1));
    chk({tag, ".almost_full"}, int'(almost_full), int'(ecnt >= 7));
    chk({tag, ".overflow"}, int'(overflow), int'(eo));
    chk({tag, ".underflow"}, int'(underflow), int'(eu));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; w_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // One model-checked cycle: head word checked before the edge, state after.
  task automatic cycle(input string tag, input logic w, input logic [7:0] d,
                       input logic r, input logic c);
    bit fullm, emptym, oe, ue;
    @(negedge clk);
    wr = w; w_data = d; rd = r; err_clr = c;
    #1;
    if (m_q.size() > 0) chk({tag, ".r_data"}, int'(r_data), int'(m_q[0]));
    fullm  = (m_q.size() == DEPTH);
    emptym = (m_q.size() == 0);
    oe = w && fullm && !r;
    ue = r && emptym;
    if (r && !emptym) void'(m_q.pop_front());
    if (w && (!fullm || r)) m_q.push_back(d);
    if (STICKY) begin
      m_ovf = oe ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = ue ? 1'b1 : (c ? 1'b0 : m_unf);
    end else begin
      m_ovf = oe;
      m_unf = ue;
    end
    @(posedge clk);
    #1;
    check_state(tag, m_q.size(), m_ovf, m_unf);
  endtask

  initial begin
    reset = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; w_data = '0;
    #1;
    check_state("reset", 0, 1'b0, 1'b0);
    do_reset();

    // Vector table: fill, overflow, drain, underflow, write-on-empty.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 0, 0, 8'(8'h11 + i), 0, 8'h00, i + 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'hAA, 1, 8'h11, 8, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h11, 8, STICKY, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 1, 8'h11, 8, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'(8'h11 + k), 7 - k, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h3C, 0, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h3C, 0, 0, STICKY));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      wr = tbl[i].wr; rd = tbl[i].rd; err_clr = tbl[i].clr; w_data = tbl[i].wd;
      #1;
      if (tbl[i].rv) chk($sformatf("vec%0d.r_data", i), int'(r_data), int'(tbl[i].exp_rd));
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), tbl[i].exp_cnt, tbl[i].exp_ovf, tbl[i].exp_unf);
    end

    // Full FIFO with simultaneous read and write.
    do_reset();
    for (int i = 0; i < 8; i++) cycle("fill", 1, 8'(8'h11 + i), 0, 0);
    @(negedge clk); wr = 1'b0; rd = 1'b0; #1;
    chk("rw_full.head", int'(r_data), 8'h11);
    cycle("rw_full", 1, 8'h55, 1, 0);
    chk("rw_full.count", int'(count), 8);
    for (int i = 0; i < 7; i++) cycle("rw_pop", 0, 8'h00, 1, 0);
    @(negedge clk); wr = 1'b0; rd = 1'b0; #1;
    chk("rw_full.last", int'(r_data), 8'h55);
    cycle("rw_last", 0, 8'h00, 1, 0);

    // Asynchronous reset with five words stored.
    do_reset();
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1, 8'(8'hA0 + i), 0, 0);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_state("async_rst", 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;

    // Steady write/read pairs across pointer wrap.
    cycle("wrap_first", 1, 8'h77, 0, 0);
    for (int i = 0; i < 20; i++) cycle("wrap", 1, 8'(8'h80 + i), 1, 0);
    chk("wrap.head", int'(r_data), 8'h93);

    // Randomized traffic in phases biased toward filling and draining.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 80; i++) begin
        logic w, r, c;
        w = ($urandom_range(99) < ((ph % 2 == 0) ? 75 : 25));
        r = ($urandom_range(99) < ((ph % 2 == 0) ? 25 : 75));
        c = ($urandom_range(7) == 0);
        cycle("rand", w, 8'($urandom), r, c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised single-clock FIFO, the next generation of the team's depth-8 synchronous FIFO. It adds generic width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and overflow/underflow error reporting. It sits between any producer/consumer pair in the same clock domain. Storage is an internal register array with asynchronous read, so the head word is always presented on `r_data` (show-ahead).

## Interface
- `DATA_WIDTH`, 8: word width in bits.
- `ADDR_WIDTH`, 3: address width; depth `DEPTH = 2**ADDR_WIDTH`.
- `AF_LEVEL`, `DEPTH-1`: `almost_full` asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- `AE_LEVEL`, 1: `almost_empty` asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `wr` input 1: write request.
- `w_data` input DATA_WIDTH: write data.
- `rd` input 1: read (pop) request.
- `r_data` output DATA_WIDTH: head-of-FIFO word; valid while `empty`=0.
- `empty` output 1: count == 0.
- `full` output 1: count == DEPTH.
- `almost_empty` output 1: count ≤ AE_LEVEL.
- `almost_full` output 1: count ≥ AF_LEVEL.
- `count` output ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `overflow` output 1: a write was dropped.
- `underflow` output 1: a read was dropped.
- `err_clr` input 1: clears the sticky error flags (see Configuration).

## Operation
- Pointers are `w_ptr` and `r_ptr`, each ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address the array; the MSB is the wrap bit. Pointers wrap naturally modulo 2·DEPTH.
- `count` is registered and updated each cycle by the accepted operations (+1, −1 or 0). All four level flags are combinational compares on `count`.
- Write accept: `wr & (~full | rd)`. Read accept: `rd & ~empty`.
- Accepted write: `mem[w_ptr]` ← `w_data`, then `w_ptr` increments.
- Accepted read: `r_ptr` increments. `r_data` = `mem[r_ptr[ADDR_WIDTH-1:0]]` (combinational).
- Simultaneous `rd` and `wr`:
  - Not empty and not full: both accepted; count unchanged.
  - Full: both accepted. The pop returns the old head; the write lands in the freed slot. Count stays DEPTH.
  - Empty: the write is accepted and the read is dropped (underflow event); count becomes 1.
- Dropped write (`wr` while full, `rd`=0) is an overflow event. Dropped read (`rd` while empty) is an underflow event. Neither changes the pointers or memory.
- Reset (asynchronous, `reset`=0):
  - `w_ptr`, `r_ptr` and `count` go to 0.
  - Outputs: `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0.
  - Memory contents are not cleared; `r_data` is don't-care while empty.
  - Reset asserted mid-operation discards all contents immediately.

## Timing
- Write-to-read latency: a word written at edge N appears on `r_data` with `empty`=0 after edge N, so it can be popped in cycle N+1.
- Read: `r_data` is valid combinationally in the same cycle `rd` is sampled. The next word appears after the edge.
- Flags and `count` change only on a `clk` edge, except at reset.
- `overflow`/`underflow` are registered and assert on the edge that samples the dropped request.
- Pointer wrap from DEPTH-1 to 0 causes no bubble or flag glitch.

## Configuration
- Macro: `FIFO_ERR_STICKY_EN`.
- Defined:
  - `overflow`/`underflow` are sticky: set by their event and held until an edge with `err_clr`=1.
  - If an event and `err_clr` occur in the same cycle, set wins.
- Undefined:
  - The flags are one-cycle pulses, high for exactly the cycle after each dropping edge.
  - `err_clr` is ignored.

## Test plan
- Reset, then write 0x11..0x18 into DEPTH=8:
  - `full`=1 and `count`=8 after the 8th edge.
  - `almost_full` (AF_LEVEL=7) rises after the 7th edge.
- Continuing from the full FIFO, pop 8 times:
  - `r_data` sequence is 0x11..0x18.
  - `empty`=1 after the 8th pop; `almost_empty` rises at count 1.
- Full FIFO, `wr`=1 with 0xAA and `rd`=0:
  - Count stays 8 and `overflow` sets.
  - With `FIFO_ERR_STICKY_EN`, it holds until `err_clr`; without it, it is a one-cycle pulse.
  - Subsequent reads still return 0x11 first.
- Full FIFO, `rd`=`wr`=1 with 0x55:
  - The pop returns the old head and count stays 8.
  - After 7 further pops, 0x55 is read last.
- Empty FIFO, `rd`=`wr`=1 with 0x3C:
  - Count becomes 1 and `underflow` asserts.
  - The next cycle `r_data`=0x3C.
- Reset asserted mid-stream with count=5: all pointers and flags return to reset values with no clock edge required. Then write 0x77 and cycle through 20 write/read pairs: data stays in order across the wrap.
